// File: rtl/pll_lock_monitor_if.sv
// Purpose : groups the observed PLL signals and the monitor's measurement
//           results into one bundle between the PLL side and the monitor.
// Ports   : vco/fb       - VCO square wave and synchronized feedback level
//           phase_err/err_valid, locked/lock_lost - phase and lock results
//           freq_count/freq_valid                 - per-gate fb edge count
//           master drives vco/fb; slave is the monitor that reports results.
interface pll_lock_monitor_if;
  logic               vco;
  logic               fb;
  logic signed [15:0] phase_err;
  logic               err_valid;
  logic               locked;
  logic               lock_lost;
  logic        [15:0] freq_count;
  logic               freq_valid;

  modport master (
    output vco, fb,
    input  phase_err, err_valid, locked, lock_lost, freq_count, freq_valid
  );

  modport slave (
    input  vco, fb,
    output phase_err, err_valid, locked, lock_lost, freq_count, freq_valid
  );
endinterface

// File: rtl/pll_lock_monitor.sv
// Purpose : passive PLL observer. Measures the signed phase error between
//           vco and fb rising edges, declares lock with hysteresis, and
//           counts fb edges per fixed gate to report frequency in kHz.
// Ports   : clk_50, rst_n (async, active-low); mon (slave modport) carries
//           vco/fb in and phase_err/err_valid/locked/lock_lost/
//           freq_count/freq_valid out. Every output is registered.
module pll_lock_monitor #(
  parameter int ERR_MAX     = 4095,
  parameter int LOCK_WIN    = 8,
  parameter int UNLOCK_WIN  = 32,
  parameter int LOCK_CNT    = 64,
  parameter int GATE_CYCLES = 50000
) (
  input  logic                 clk_50,
  input  logic                 rst_n,
  pll_lock_monitor_if.slave    mon
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [15:0]       ERR_MAX_C    = 16'(ERR_MAX);
  localparam logic [15:0]       ERR_MAX_NEG  = 16'd0 - 16'(ERR_MAX);
  localparam logic [15:0]       LOCK_WIN_C   = 16'(LOCK_WIN);
  localparam logic [15:0]       UNLOCK_WIN_C = 16'(UNLOCK_WIN);
  localparam logic [GOOD_W-1:0] LOCK_CNT_C   = GOOD_W'(LOCK_CNT);
  localparam logic [GATE_W-1:0] GATE_LAST    = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FB  = 2'd1,
    WAIT_VCO = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Edge detection. History resets to 1 so a level already high when reset
  // is released does not register as a rising edge.
  // ---------------------------------------------------------------------------
  logic vco_prev_q;
  logic fb_prev_q;
  logic vco_rise;
  logic fb_rise;

  assign vco_rise = mon.vco & ~vco_prev_q;
  assign fb_rise  = mon.fb  & ~fb_prev_q;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      vco_prev_q <= 1'b1;
      fb_prev_q  <= 1'b1;
    end else begin
      vco_prev_q <= mon.vco;
      fb_prev_q  <= mon.fb;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase measurement FSM. The first edge of a pair starts cnt at 1; the
  // opposite edge closes the measurement and is consumed. Sign convention:
  // fb first (VCO lagging) is positive.
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] phase_err_q;
  logic        err_valid_q;
  logic [15:0] cnt_neg;

  assign cnt_neg = 16'd0 - cnt_q;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      phase_err_q <= '0;
      err_valid_q <= 1'b0;
    end else begin
      err_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vco_rise && fb_rise) begin
            phase_err_q <= '0;
            err_valid_q <= 1'b1;
          end else if (vco_rise) begin
            cnt_q   <= 16'd1;
            state_q <= WAIT_FB;
          end else if (fb_rise) begin
            cnt_q   <= 16'd1;
            state_q <= WAIT_VCO;
          end
        end

        WAIT_FB: begin
          // Further vco edges are ignored; only fb can close the pair.
          if (fb_rise) begin
            phase_err_q <= cnt_neg;
            err_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else if (cnt_q >= ERR_MAX_C) begin
            phase_err_q <= ERR_MAX_NEG;
            err_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        WAIT_VCO: begin
          if (vco_rise) begin
            phase_err_q <= cnt_q;
            err_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else if (cnt_q >= ERR_MAX_C) begin
            phase_err_q <= ERR_MAX_C;
            err_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Lock detector with hysteresis, driven by the registered measurement.
  // Errors between LOCK_WIN and UNLOCK_WIN leave the state untouched.
  // ---------------------------------------------------------------------------
  logic [15:0]       err_mag;
  logic [GOOD_W-1:0] good_cnt_q;
  logic [GOOD_W-1:0] good_cnt_d;
  logic              locked_q;
  logic              locked_d;
  logic              lock_lost_q;
  logic              lock_lost_d;

  assign err_mag = phase_err_q[15] ? (16'd0 - phase_err_q) : phase_err_q;

  always_comb begin
    good_cnt_d  = good_cnt_q;
    locked_d    = locked_q;
    lock_lost_d = 1'b0;
    if (err_valid_q) begin
      if (err_mag <= LOCK_WIN_C) begin
        if (good_cnt_q < LOCK_CNT_C) begin
          good_cnt_d = good_cnt_q + GOOD_W'(1);
        end
        if (good_cnt_d == LOCK_CNT_C) begin
          locked_d = 1'b1;
        end
      end else if (err_mag > UNLOCK_WIN_C) begin
        good_cnt_d  = '0;
        locked_d    = 1'b0;
        lock_lost_d = locked_q;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt_q  <= '0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      good_cnt_q  <= good_cnt_d;
      locked_q    <= locked_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frequency gate. An fb edge landing on the last gate cycle belongs to the
  // window that is closing, so it is folded into the reported count.
  // ---------------------------------------------------------------------------
  logic [GATE_W-1:0] gate_ctr_q;
  logic [GATE_W-1:0] gate_ctr_d;
  logic [15:0]       edge_ctr_q;
  logic [15:0]       edge_ctr_d;
  logic [15:0]       edge_sum;
  logic [15:0]       freq_count_q;
  logic [15:0]       freq_count_d;
  logic              freq_valid_q;
  logic              freq_valid_d;
  logic              gate_end;

  assign gate_end = (gate_ctr_q == GATE_LAST);
  assign edge_sum = (fb_rise && (edge_ctr_q != 16'hFFFF)) ? (edge_ctr_q + 16'd1)
                                                           : edge_ctr_q;

  always_comb begin
    gate_ctr_d   = gate_ctr_q + GATE_W'(1);
    edge_ctr_d   = edge_sum;
    freq_count_d = freq_count_q;
    freq_valid_d = 1'b0;
    if (gate_end) begin
      gate_ctr_d   = '0;
      edge_ctr_d   = '0;
      freq_count_d = edge_sum;
      freq_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      gate_ctr_q   <= '0;
      edge_ctr_q   <= '0;
      freq_count_q <= '0;
      freq_valid_q <= 1'b0;
    end else begin
      gate_ctr_q   <= gate_ctr_d;
      edge_ctr_q   <= edge_ctr_d;
      freq_count_q <= freq_count_d;
      freq_valid_q <= freq_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mon.phase_err  = $signed(phase_err_q);
  assign mon.err_valid  = err_valid_q;
  assign mon.locked     = locked_q;
  assign mon.lock_lost  = lock_lost_q;
  assign mon.freq_count = freq_count_q;
  assign mon.freq_valid = freq_valid_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Purpose : self-checking bench for pll_lock_monitor. A timestamp-based
//           reference model predicts every output on every cycle; directed
//           checks cover lock, hysteresis, timeout, gate boundary,
//           edge-counter saturation (short-gate instance) and async reset.
module tb_pll_lock_monitor;

  localparam int ERR_MAX    = 4095;
  localparam int LOCK_WIN   = 8;
  localparam int UNLOCK_WIN = 32;
  localparam int LOCK_CNT   = 64;
  localparam int GATE       = 50000;
  localparam int SAT_GATE   = 64;

  logic clk_50 = 1'b0;
  logic rst_n;
  logic sat_rst_n;
  logic sat_fb;

  always #10 clk_50 = ~clk_50;

  pll_lock_monitor_if mif ();
  pll_lock_monitor_if sif ();

  pll_lock_monitor #(
    .ERR_MAX(ERR_MAX), .LOCK_WIN(LOCK_WIN), .UNLOCK_WIN(UNLOCK_WIN),
    .LOCK_CNT(LOCK_CNT), .GATE_CYCLES(GATE)
  ) u_dut (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .mon    (mif)
  );

  pll_lock_monitor #(
    .ERR_MAX(ERR_MAX), .LOCK_WIN(LOCK_WIN), .UNLOCK_WIN(UNLOCK_WIN),
    .LOCK_CNT(LOCK_CNT), .GATE_CYCLES(SAT_GATE)
  ) u_sat (
    .clk_50 (clk_50),
    .rst_n  (sat_rst_n),
    .mon    (sif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int lost_seen = 0;
  int to_seen   = 0;

  // Reference model state: pending measurement kept as a start timestamp.
  int t;
  bit vp, fp;
  int pend;      // 0 none, 1 vco opened (waiting fb), 2 fb opened (waiting vco)
  int st;
  int m_pe;
  bit m_ev, m_lk, m_lost;
  int good;
  int gedges;
  int m_fc;
  bit m_fv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; vp = 1'b1; fp = 1'b1; pend = 0; st = 0;
    m_pe = 0; m_ev = 1'b0; m_lk = 1'b0; m_lost = 1'b0; good = 0;
    gedges = 0; m_fc = 0; m_fv = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit f);
    bit vr, fr, closing, n_lk, n_lost;
    int mag, age;
    vr = v && !vp;
    fr = f && !fp;
    // lock decision uses the measurement reported in the previous cycle
    n_lk = m_lk;
    n_lost = 1'b0;
    if (m_ev) begin
      mag = (m_pe < 0) ? -m_pe : m_pe;
      if (mag <= LOCK_WIN) begin
        if (good < LOCK_CNT) good++;
        if (good >= LOCK_CNT) n_lk = 1'b1;
      end else if (mag > UNLOCK_WIN) begin
        good = 0;
        n_lost = m_lk;
        n_lk = 1'b0;
      end
    end
    m_ev = 1'b0;
    if (pend == 0) begin
      if (vr && fr) begin m_pe = 0; m_ev = 1'b1; end
      else if (vr) begin pend = 1; st = t; end
      else if (fr) begin pend = 2; st = t; end
    end else begin
      age = t - st;
      closing = (pend == 1) ? fr : vr;
      if (closing || age >= ERR_MAX) begin
        mag = closing ? age : ERR_MAX;
        m_pe = (pend == 1) ? -mag : mag;
        m_ev = 1'b1;
        pend = 0;
      end
    end
    m_fv = 1'b0;
    if (fr) gedges++;
    if ((t % GATE) == GATE - 1) begin
      m_fc = (gedges > 65535) ? 65535 : gedges;
      m_fv = 1'b1;
      gedges = 0;
    end
    m_lk = n_lk;
    m_lost = n_lost;
    vp = v;
    fp = f;
    t++;
  endtask

  task automatic step(input bit v, input bit f);
    mif.vco = v;
    mif.fb  = f;
    sif.vco = 1'b0;
    sif.fb  = sat_fb;
    @(posedge clk_50);
    #1;
    model_step(v, f);
    chk("phase_err",  {{16{mif.phase_err[15]}}, mif.phase_err}, m_pe);
    chk("err_valid",  {31'd0, mif.err_valid},  {31'd0, m_ev});
    chk("locked",     {31'd0, mif.locked},     {31'd0, m_lk});
    chk("lock_lost",  {31'd0, mif.lock_lost},  {31'd0, m_lost});
    chk("freq_count", {16'd0, mif.freq_count}, m_fc);
    chk("freq_valid", {31'd0, mif.freq_valid}, {31'd0, m_fv});
    if (mif.lock_lost === 1'b1) lost_seen++;
    if (mif.err_valid === 1'b1 && mif.phase_err == -16'sd4095) to_seen++;
  endtask

  // One self-contained edge pair: fb high [50,80), vco delayed by d.
  task automatic run_pairs(input int n, input int d);
    for (int j = 0; j < n; j++) begin
      int p;
      p = $urandom_range(120, 140);
      for (int k = 0; k < p; k++)
        step((k >= 50 + d) && (k < 80 + d), (k >= 50) && (k < 80));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_phase_err"},  {16'd0, mif.phase_err}, 0);
    chk({tag, "_err_valid"},  {31'd0, mif.err_valid}, 0);
    chk({tag, "_locked"},     {31'd0, mif.locked}, 0);
    chk({tag, "_lock_lost"},  {31'd0, mif.lock_lost}, 0);
    chk({tag, "_freq_count"}, {16'd0, mif.freq_count}, 0);
    chk({tag, "_freq_valid"}, {31'd0, mif.freq_valid}, 0);
  endtask

  initial begin
    int l0, to0;
    bit rv, rf;
    logic [15:0] sat_exp [4];
    sat_exp[0] = 16'd3; sat_exp[1] = 16'd2; sat_exp[2] = 16'hFFFF; sat_exp[3] = 16'd1;

    rst_n = 1'b0; sat_rst_n = 1'b0; sat_fb = 1'b0;
    mif.vco = 1'b0; mif.fb = 1'b0; sif.vco = 1'b0; sif.fb = 1'b0;
    repeat (3) @(posedge clk_50);
    #1;
    check_all_zero("reset");
    @(negedge clk_50);
    rst_n = 1'b1;
    model_reset();

    // Lagging VCO by 5: locks; then lag 40 drops lock with one lock_lost.
    run_pairs(70, 5);
    chk("lag5_locked", {31'd0, mif.locked}, 1);
    l0 = lost_seen;
    run_pairs(10, 40);
    chk("lag40_locked", {31'd0, mif.locked}, 0);
    chk("lag40_lost_pulses", lost_seen - l0, 1);

    // Aligned edges: zero error, relock.
    run_pairs(80, 0);
    chk("aligned_locked", {31'd0, mif.locked}, 1);

    // Timeout: fb held low, four vco pulses each time out at -ERR_MAX.
    to0 = to_seen;
    for (int k = 0; k < 4 * 5000; k++) step((k % 5000) < 2500, 1'b0);
    chk("timeout_count", to_seen - to0, 4);
    chk("timeout_locked", {31'd0, mif.locked}, 0);
    chk("timeout_freq_count", {16'd0, mif.freq_count}, 0);

    // Random activity up to the gate end, with an fb edge on the last cycle.
    rv = 1'b0; rf = 1'b0;
    while (t < GATE - 2) begin
      if ($urandom_range(0, 15) == 0) rv = ~rv;
      if ($urandom_range(0, 15) == 0) rf = ~rf;
      step(rv, rf);
    end
    step(rv, 1'b0);
    step(rv, 1'b1);
    chk("gate_end_freq_valid", {31'd0, mif.freq_valid}, 1);
    repeat (ERR_MAX + 20) step(1'b0, 1'b0);

    // Hysteresis: relock, then -20 errors and a single +4 keep lock.
    run_pairs(70, 5);
    chk("relock_locked", {31'd0, mif.locked}, 1);
    l0 = lost_seen;
    run_pairs(10, -20);
    chk("hyst_locked", {31'd0, mif.locked}, 1);
    run_pairs(1, 4);
    chk("hyst_small_locked", {31'd0, mif.locked}, 1);
    run_pairs(2, -20);
    chk("hyst_locked2", {31'd0, mif.locked}, 1);
    chk("hyst_lost_pulses", lost_seen - l0, 0);

    // Short-gate instance: boundary edge, carry-free next gate, saturation.
    @(negedge clk_50);
    sat_rst_n = 1'b1;
    for (int s = 0; s < 4 * SAT_GATE; s++) begin
      sat_fb = (s == 10 || s == 20 || s == 63 || s == 64 || s == 80 || s == 90 ||
                s == 150 || s == 160 || s == 191 || s == 192 || s == 200);
      if (s == 130) force u_sat.edge_ctr_q = 16'hFFFE;
      step(1'b0, 1'b0);
      if (s == 130) release u_sat.edge_ctr_q;
      if ((s % SAT_GATE) == SAT_GATE - 1) begin
        chk("sat_freq_valid", {31'd0, sif.freq_valid}, 1);
        chk("sat_freq_count", {16'd0, sif.freq_count}, {16'd0, sat_exp[s / SAT_GATE]});
      end else if ((s % SAT_GATE) == SAT_GATE - 2) begin
        chk("sat_freq_valid_idle", {31'd0, sif.freq_valid}, 0);
      end
    end
    sat_fb = 1'b0;

    // Async reset while waiting for fb with lock held.
    repeat (3) step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    chk("pre_rst_locked", {31'd0, mif.locked}, 1);
    @(negedge clk_50);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    mif.vco = 1'b1; mif.fb = 1'b1;
    @(posedge clk_50);
    #1;
    check_all_zero("rst_held");
    @(negedge clk_50);
    rst_n = 1'b1;
    model_reset();
    repeat (3) step(1'b1, 1'b1);
    chk("post_rst_no_edge", {31'd0, mif.err_valid}, 0);
    step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("post_rst_pe", {{16{mif.phase_err[15]}}, mif.phase_err}, 3);
    chk("post_rst_ev", {31'd0, mif.err_valid}, 1);
    repeat (3) step(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
